// File: rtl/food_placer.sv
// Food placement controller: random LFSR draws with off-grid and occupancy
// rejection, falling back to a row-major scan once the draw budget runs out.
module food_placer #(
    parameter int GRID_W    = 16,
    parameter int GRID_H    = 12,
    parameter int MAX_TRIES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [7:0] rand0,
    input  logic [7:0] rand1,
    output logic       query_valid,
    output logic [3:0] query_x,
    output logic [3:0] query_y,
    input  logic       occupied,
    output logic [3:0] food_x,
    output logic [3:0] food_y,
    output logic       busy,
    output logic       done,
    output logic       fail
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_QUERY,
        S_CHECK,
        S_SCAN_Q,
        S_SCAN_CHK,
        S_DONE,
        S_FAIL
    } state_t;

    localparam logic [4:0] LP_W    = 5'(GRID_W);
    localparam logic [4:0] LP_H    = 5'(GRID_H);
    localparam logic [3:0] LP_XL   = 4'(GRID_W - 1);
    localparam logic [3:0] LP_YL   = 4'(GRID_H - 1);
    localparam logic [7:0] LP_MAXT = 8'(MAX_TRIES);

    state_t     r_state;
    logic [7:0] r_tries;
    logic [3:0] r_cx;
    logic [3:0] r_cy;
    logic [3:0] r_sx;
    logic [3:0] r_sy;
    logic       r_qv;
    logic [3:0] r_qx;
    logic [3:0] r_qy;
    logic [3:0] r_fx;
    logic [3:0] r_fy;
    logic       r_busy;
    logic       r_done;
    logic       r_fail;

    logic [3:0] w_cx;
    logic [3:0] w_cy;
    logic       w_in_range;
    logic [7:0] w_tries_inc;
    logic       w_row_end;
    logic       w_scan_end;
    logic [3:0] w_sx_nx;
    logic [3:0] w_sy_nx;
    logic       w_unused;

    assign w_cx        = rand0[3:0];
    assign w_cy        = rand1[3:0];
    assign w_in_range  = ({1'b0, w_cx} < LP_W) && ({1'b0, w_cy} < LP_H);
    assign w_tries_inc = r_tries + 8'd1;
    assign w_row_end   = (r_sx == LP_XL);
    assign w_scan_end  = w_row_end && (r_sy == LP_YL);
    assign w_sx_nx     = w_row_end ? 4'd0 : r_sx + 4'd1;
    assign w_sy_nx     = w_row_end ? r_sy + 4'd1 : r_sy;
    assign w_unused    = ^{rand0[7:4], rand1[7:4]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_tries <= 8'd0;
            r_cx    <= 4'd0;
            r_cy    <= 4'd0;
            r_sx    <= 4'd0;
            r_sy    <= 4'd0;
            r_qv    <= 1'b0;
            r_qx    <= 4'd0;
            r_qy    <= 4'd0;
            r_fx    <= 4'd0;
            r_fy    <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_fail  <= 1'b0;
        end else begin
            r_qv   <= 1'b0;
            r_done <= 1'b0;
            r_fail <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_tries <= 8'd0;
                    r_sx    <= 4'd0;
                    r_sy    <= 4'd0;
                    r_busy  <= 1'b0;
                    if (req) begin
                        r_state <= S_SAMPLE;
                        r_busy  <= 1'b1;
                    end
                end
                S_SAMPLE: begin
                    r_tries <= w_tries_inc;
                    if (w_in_range) begin
                        r_cx    <= w_cx;
                        r_cy    <= w_cy;
                        r_qv    <= 1'b1;
                        r_qx    <= w_cx;
                        r_qy    <= w_cy;
                        r_state <= S_QUERY;
                    end else if (w_tries_inc == LP_MAXT) begin
                        r_sx    <= 4'd0;
                        r_sy    <= 4'd0;
                        r_qv    <= 1'b1;
                        r_qx    <= 4'd0;
                        r_qy    <= 4'd0;
                        r_state <= S_SCAN_Q;
                    end else begin
                        r_state <= S_SAMPLE;
                    end
                end
                S_QUERY: begin
                    r_state <= S_CHECK;
                end
                // tries was already bumped in SAMPLE, so compare directly
                S_CHECK: begin
                    if (!occupied) begin
                        r_fx    <= r_cx;
                        r_fy    <= r_cy;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_tries == LP_MAXT) begin
                        r_sx    <= 4'd0;
                        r_sy    <= 4'd0;
                        r_qv    <= 1'b1;
                        r_qx    <= 4'd0;
                        r_qy    <= 4'd0;
                        r_state <= S_SCAN_Q;
                    end else begin
                        r_state <= S_SAMPLE;
                    end
                end
                S_SCAN_Q: begin
                    r_state <= S_SCAN_CHK;
                end
                S_SCAN_CHK: begin
                    if (!occupied) begin
                        r_fx    <= r_sx;
                        r_fy    <= r_sy;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (w_scan_end) begin
                        r_fail  <= 1'b1;
                        r_state <= S_FAIL;
                    end else begin
                        r_sx    <= w_sx_nx;
                        r_sy    <= w_sy_nx;
                        r_qv    <= 1'b1;
                        r_qx    <= w_sx_nx;
                        r_qy    <= w_sy_nx;
                        r_state <= S_SCAN_Q;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_FAIL: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign query_valid = r_qv;
    assign query_x     = r_qx;
    assign query_y     = r_qy;
    assign food_x      = r_fx;
    assign food_y      = r_fy;
    assign busy        = r_busy;
    assign done        = r_done;
    assign fail        = r_fail;

endmodule

// File: tb/tb_food_placer.sv
// Directed bench for food_placer: scoreboard of expected placements,
// occupancy model answering one cycle after each lookup.
module tb_food_placer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req = 1'b0;
    logic [7:0] rand0 = 8'h00;
    logic [7:0] rand1 = 8'h00;
    logic       occupied = 1'b1;
    logic       query_valid;
    logic [3:0] query_x;
    logic [3:0] query_y;
    logic [3:0] food_x;
    logic [3:0] food_y;
    logic       busy;
    logic       done;
    logic       fail;

    always #5 clk = ~clk;

    food_placer #(
        .GRID_W(16),
        .GRID_H(12),
        .MAX_TRIES(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .rand0(rand0),
        .rand1(rand1),
        .query_valid(query_valid),
        .query_x(query_x),
        .query_y(query_y),
        .occupied(occupied),
        .food_x(food_x),
        .food_y(food_y),
        .busy(busy),
        .done(done),
        .fail(fail)
    );

    typedef struct {
        logic       is_fail;
        logic [3:0] x;
        logic [3:0] y;
        int         lat;
    } exp_t;

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        int         t;
    } qry_t;

    exp_t exp_q[$];
    qry_t qlog[$];
    bit   occ_map[256];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_done = 0;
    int   n_fail = 0;
    int   n_consec = 0;
    int   t_req = 0;
    logic prev_qv = 1'b0;

    // occupancy answers the lookup one cycle later; high elsewhere
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (query_valid) occupied <= occ_map[{query_y, query_x}];
        else occupied <= 1'b1;
    end

    always @(negedge clk) begin
        if (query_valid) begin
            qlog.push_back('{query_x, query_y, cyc});
            if (prev_qv) n_consec++;
        end
        prev_qv = query_valid;
        if (done) n_done++;
        if (fail) n_fail++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_q(input string tag, input int idx,
                           input logic [3:0] x, input logic [3:0] y,
                           input int t);
        if (qlog.size() > idx) begin
            check({tag, "_xy"}, {qlog[idx].x, qlog[idx].y}, {x, y});
            check({tag, "_t"}, qlog[idx].t, t);
        end else begin
            check({tag, "_present"}, qlog.size(), idx + 1);
        end
    endtask

    task automatic wait_result(input string tag, input int budget);
        exp_t e;
        bit   got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            got = done | fail;
        end
        check({tag, "_seen"}, got, 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (got) begin
                check({tag, "_kind"}, {done, fail},
                      e.is_fail ? 2'b01 : 2'b10);
                check({tag, "_food"}, {food_x, food_y}, {e.x, e.y});
                check({tag, "_lat"}, cyc - t_req, e.lat);
            end
        end
    endtask

    task automatic set_occ_all(input bit v);
        for (int i = 0; i < 256; i++) occ_map[i] = v;
    endtask

    initial begin
        int nd0;
        int nf0;
        int n35;

        set_occ_all(1'b0);
        rst = 1'b0;
        tick();
        tick();
        check("rst_food", {food_x, food_y}, 0);
        check("rst_query", {query_x, query_y}, 0);
        check("rst_ctl", {busy, done, fail, query_valid}, 0);
        rst = 1'b1;
        tick();
        tick();
        check("idle_busy", busy, 0);

        // single draw
        qlog.delete();
        rand0 = 8'h03;
        rand1 = 8'h05;
        req = 1'b1;
        t_req = cyc;
        exp_q.push_back('{1'b0, 4'd3, 4'd5, 4});
        tick();
        req = 1'b0;
        check("t1_busy_e1", busy, 1);
        check("t1_noq_e1", query_valid, 0);
        wait_result("t1", 50);
        check("t1_busy_done", busy, 1);
        check("t1_nq", qlog.size(), 1);
        check_q("t1_q", 0, 4'd3, 4'd5, t_req + 2);
        tick();
        check("t1_after", {busy, done}, 0);

        // range reject on the first draw
        qlog.delete();
        rand0 = 8'h07;
        rand1 = 8'h0E;
        req = 1'b1;
        t_req = cyc;
        exp_q.push_back('{1'b0, 4'd7, 4'd2, 5});
        tick();
        req = 1'b0;
        tick();
        rand1 = 8'h02;
        wait_result("t2", 50);
        check("t2_nq", qlog.size(), 1);
        check_q("t2_q", 0, 4'd7, 4'd2, t_req + 3);
        tick();

        // fallback scan after MAX_TRIES occupied draws
        qlog.delete();
        rand0 = 8'h03;
        rand1 = 8'h05;
        occ_map[{4'd5, 4'd3}] = 1'b1;
        occ_map[{4'd0, 4'd0}] = 1'b1;
        occ_map[{4'd0, 4'd1}] = 1'b1;
        req = 1'b1;
        t_req = cyc;
        exp_q.push_back('{1'b0, 4'd2, 4'd0, 103});
        tick();
        req = 1'b0;
        wait_result("t3", 300);
        check("t3_nq", qlog.size(), 35);
        n35 = 0;
        for (int i = 0; i < 32 && i < qlog.size(); i++)
            if (qlog[i].x == 4'd3 && qlog[i].y == 4'd5) n35++;
        check("t3_rand_q", n35, 32);
        check_q("t3_s0", 32, 4'd0, 4'd0, t_req + 97);
        check_q("t3_s1", 33, 4'd1, 4'd0, t_req + 99);
        check_q("t3_s2", 34, 4'd2, 4'd0, t_req + 101);
        tick();

        // full grid
        qlog.delete();
        set_occ_all(1'b1);
        nd0 = n_done;
        nf0 = n_fail;
        req = 1'b1;
        t_req = cyc;
        exp_q.push_back('{1'b1, 4'd2, 4'd0, 481});
        tick();
        req = 1'b0;
        wait_result("t4", 700);
        tick();
        tick();
        check("t4_nq", qlog.size(), 224);
        check("t4_fails", n_fail - nf0, 1);
        check("t4_dones", n_done - nd0, 0);
        check("t4_idle", {busy, fail}, 0);
        check("t4_consec", n_consec, 0);

        // reset during SCAN_CHK
        req = 1'b1;
        t_req = cyc;
        tick();
        req = 1'b0;
        repeat (97) tick();
        check("t5_busy_pre", busy, 1);
        nd0 = n_done;
        nf0 = n_fail;
        rst = 1'b0;
        #1;
        check("t5_rst_food", {food_x, food_y}, 0);
        check("t5_rst_query", {query_x, query_y}, 0);
        check("t5_rst_ctl", {busy, done, fail, query_valid}, 0);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        tick();
        check("t5_no_pulse", (n_done - nd0) + (n_fail - nf0), 0);
        set_occ_all(1'b0);
        rand0 = 8'h03;
        rand1 = 8'h05;
        req = 1'b1;
        t_req = cyc;
        exp_q.push_back('{1'b0, 4'd3, 4'd5, 4});
        tick();
        req = 1'b0;
        wait_result("t5", 50);
        tick();

        // back-to-back with req held high
        rand0 = 8'h0A;
        rand1 = 8'h0B;
        nd0 = n_done;
        req = 1'b1;
        t_req = cyc;
        exp_q.push_back('{1'b0, 4'd10, 4'd11, 4});
        exp_q.push_back('{1'b0, 4'd10, 4'd11, 5});
        exp_q.push_back('{1'b0, 4'd10, 4'd11, 5});
        wait_result("t6a", 50);
        t_req = cyc;
        wait_result("t6b", 50);
        t_req = cyc;
        wait_result("t6c", 50);
        req = 1'b0;
        repeat (10) tick();
        check("t6_dones", n_done - nd0, 3);

        // req pulse while busy is dropped
        nd0 = n_done;
        req = 1'b1;
        t_req = cyc;
        exp_q.push_back('{1'b0, 4'd10, 4'd11, 4});
        tick();
        req = 1'b0;
        tick();
        req = 1'b1;
        tick();
        req = 1'b0;
        wait_result("t7", 50);
        repeat (10) tick();
        check("t7_dones", n_done - nd0, 1);

        // range rejects alone exhaust the draw budget
        qlog.delete();
        rand0 = 8'h0F;
        rand1 = 8'h0E;
        req = 1'b1;
        t_req = cyc;
        exp_q.push_back('{1'b0, 4'd0, 4'd0, 35});
        tick();
        req = 1'b0;
        wait_result("t8", 100);
        check("t8_nq", qlog.size(), 1);
        check_q("t8_q", 0, 4'd0, 4'd0, t_req + 33);
        tick();

        check("end_consec", n_consec, 0);
        check("end_queue", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/food_placer.md
# food_placer

Food-placement controller for the snake game. On a request from the game FSM it draws candidate cells from the two 8-bit LFSR outputs and rejects any candidate that is off-grid or occupied by the snake body. If too many random tries fail, it falls back to a deterministic row-major scan so that it always terminates. It sits between the random-number generator, the snake-body occupancy lookup and the game FSM.

## Interface
- GRID_W, 16, grid width in cells (2..16)
- GRID_H, 12, grid height in cells (2..16)
- MAX_TRIES, 32, random samples allowed before fallback scan (1..255)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  1  placement request, level, sampled only in IDLE
- rand0  in  8  random source for X; bits [3:0] used
- rand1  in  8  random source for Y; bits [3:0] used
- query_valid  out  1  occupancy lookup strobe
- query_x  out  4  lookup cell X
- query_y  out  4  lookup cell Y
- occupied  in  1  lookup result, valid exactly 1 cycle after query_valid
- food_x  out  4  placed food X, registered
- food_y  out  4  placed food Y, registered
- busy  out  1  high in every state except IDLE
- done  out  1  1-cycle pulse: food_x/food_y updated this cycle
- fail  out  1  1-cycle pulse: grid full, food unchanged

## Operation
- States: IDLE, SAMPLE, QUERY, CHECK, SCAN_Q, SCAN_CHK, DONE, FAIL.
- IDLE: clear tries and scan position; req=1 -> SAMPLE.
- SAMPLE: cx=rand0[3:0], cy=rand1[3:0]; tries+1.
  - cx>=GRID_W or cy>=GRID_H: range reject.
  - Otherwise latch (cx,cy) -> QUERY.
- QUERY: query_valid=1, query_x/y = candidate -> CHECK.
- CHECK: sample occupied.
  - 0: -> DONE with food <= candidate.
  - 1: occupancy reject.
- On any reject: tries (post-increment) == MAX_TRIES -> SCAN_Q with scan (0,0); else -> SAMPLE. The LFSR advances every clock, so each SAMPLE sees fresh values.
- SCAN_Q: query_valid=1 at the scan position -> SCAN_CHK.
- SCAN_CHK: sample occupied.
  - 0: -> DONE with food <= scan position.
  - 1 at (GRID_W-1,GRID_H-1): -> FAIL.
  - 1 elsewhere: x+1; at GRID_W-1, x wraps to 0 and y+1 -> SCAN_Q.
- DONE: done=1 for one cycle -> IDLE. FAIL: fail=1 for one cycle -> IDLE.
- req while busy: ignored, not queued. req still high in IDLE after DONE or FAIL starts a new placement.
- query_x/y hold their last value when query_valid=0. occupied is ignored outside CHECK and SCAN_CHK.
- Reset mid-operation: immediate return to IDLE. The placement is abandoned and no done or fail is produced.

## Timing
- Reset values: food_x=0, food_y=0, query_x=0, query_y=0; busy, done, fail and query_valid all 0; state IDLE, tries 0.
- Outputs are registered: done is high in the DONE state cycle and food_x/y are valid from that same edge.
- Best-case latency, with req sampled at edge 0:
  - SAMPLE at 1, QUERY at 2 (query_valid high), CHECK at 3, DONE at 4.
  - Every range reject adds 1 cycle.
  - Every occupancy reject adds 3 cycles.
- Scan: 2 cycles per cell.
- Worst case, all in-range and occupied: 3*MAX_TRIES + 2*GRID_W*GRID_H + 1 cycles from req to fail.
- Bound on query_valid: it is high for exactly one cycle per lookup, and never on two consecutive cycles.

## Test plan
- Single draw: rand0=8'h03, rand1=8'h05, occupied=0, req pulse at edge 0 -> query_valid with (3,5) at edge 2; done at edge 4; food=(3,5); busy high for edges 1-4.
- Range reject: rand1=8'h0E at edge 1, then 8'h02, rand0=8'h07, occupied=0 -> no query at edge 2; query (7,2) at edge 3; done at edge 5; food=(7,2).
- Fallback scan: rand fixed at 03/05; occupied=1 for (3,5), (0,0) and (1,0) -> 32 queries of (3,5), then scan queries (0,0), (1,0), (2,0); done with food=(2,0).
- Full grid: occupied=1 always -> exactly 32+192 lookups; fail pulses once; done never asserts; food keeps its previous value.
- Reset mid-scan: deassert rst during SCAN_CHK -> all outputs at reset values immediately. After release, req with rand 03/05 and occupied=0 -> done 4 cycles later with food=(3,5).
- Back-to-back: req held high, occupied=0 -> DONE, IDLE, SAMPLE repeat, giving a done every 5 cycles. A req pulse injected while busy does not create an extra done.
